// File: rtl/tiny_alu.sv
// tiny_alu: start/done responder ALU. Operands and opcode are latched on the
// capture edge. Single-cycle ops finish one edge later; MUL runs through a
// capture -> product -> result pipeline whose length is set by MUL_LAT.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | armed, waiting for start
// S_MUL_STG | multiply in flight, down-counter running to terminal count
// S_DONE    | result loads and done pulses on the edge leaving this state
// S_REARM   | waiting for start to be sampled low before re-arming
module tiny_alu #(
  parameter int OP_W    = 8,
  parameter int MUL_LAT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OP_W-1:0]   A,
  input  logic [OP_W-1:0]   B,
  input  logic [2:0]        opcode,
  input  logic              start,
  output logic              done,
  output logic [2*OP_W-1:0] result,
  output logic              busy
);

  localparam int RW = 2 * OP_W;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_NOT = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;
  localparam logic [2:0] OP_INC = 3'd6;

  // MUL_STG lasts MUL_LAT-1 cycles, so the counter starts at MUL_LAT-2.
  localparam logic [1:0] CNT_INIT = 2'(MUL_LAT - 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL_STG,
    S_DONE,
    S_REARM
  } state_t;

  state_t          state, state_n;
  logic [OP_W-1:0] a_q, b_q;
  logic [2:0]      op_q;
  logic [1:0]      cnt;
  logic [RW-1:0]   prod_q;
  logic [RW-1:0]   a_ext, b_ext;
  logic [RW-1:0]   alu_res;
  logic            capture;
  logic            load;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next-state decode.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    if (start) state_n = (opcode == OP_MUL) ? S_MUL_STG : S_DONE;
      S_MUL_STG: if (cnt == 2'd0) state_n = S_DONE;
      S_DONE:    state_n = S_REARM;
      S_REARM:   if (!start) state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  // FSM-derived controls; busy comes straight off the state register.
  always_comb begin
    busy    = (state != S_IDLE);
    capture = (state == S_IDLE) && start;
    load    = (state == S_DONE);
  end

  // Operand/opcode capture; later input changes cannot reach the command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= OP_NOP;
    end else if (capture) begin
      a_q  <= A;
      b_q  <= B;
      op_q <= opcode;
    end
  end

  // MUL latency down-counter, loaded on capture, held at terminal count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  cnt <= 2'd0;
    else if (capture)                           cnt <= CNT_INIT;
    else if (state == S_MUL_STG && cnt != 2'd0) cnt <= cnt - 2'd1;
  end

  assign a_ext = {{OP_W{1'b0}}, a_q};
  assign b_ext = {{OP_W{1'b0}}, b_q};

  // Product stage: free-running off the captured operands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) prod_q <= '0;
    else       prod_q <= a_ext * b_ext;
  end

  // Single-cycle operations; reserved opcode behaves as NOP.
  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_ADD:  alu_res = a_ext + b_ext;
      OP_SUB:  alu_res = a_ext - b_ext;
      OP_NOT:  alu_res = {{OP_W{1'b0}}, ~a_q};
      OP_AND:  alu_res = a_ext & b_ext;
      OP_INC:  alu_res = a_ext + b_ext + RW'(1);
      default: alu_res = '0;
    endcase
  end

  // Completion: result and done update together on the edge leaving S_DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= load;
      if (load) result <= (op_q == OP_MUL) ? prod_q : alu_res;
    end
  end

endmodule

// File: tb/tb_tiny_alu.sv
// Directed bench for tiny_alu (OP_W=8, MUL_LAT=3). Inputs are driven and
// outputs sampled 1 time unit after the rising edge.
module tb_tiny_alu;

  logic        clk;
  logic        reset;
  logic [7:0]  A, B;
  logic [2:0]  opcode;
  logic        start;
  logic        done;
  logic [15:0] result;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;

  tiny_alu #(.OP_W(8), .MUL_LAT(3)) dut (
    .clk    (clk),
    .reset  (reset),
    .A      (A),
    .B      (B),
    .opcode (opcode),
    .start  (start),
    .done   (done),
    .result (result),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Called at #1 after an edge with the DUT in IDLE. Captures on the next
  // edge (N), expects done/result after edge N+lat, optionally keeps start
  // high for 'hold' extra edges after done, then re-arms.
  task automatic run_cmd(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input logic [15:0] exp, input int lat,
                         input bit scramble, input int hold);
    A = a; B = b; opcode = op; start = 1'b1;
    @(posedge clk); #1;
    if (scramble) begin A = 8'h00; B = 8'h00; end
    chk({tag, "_busy_cap"}, busy, 1);
    chk({tag, "_done_cap"}, done, 0);
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      if (k < lat) begin
        chk({tag, "_done_early"}, done, 0);
        chk({tag, "_busy_run"}, busy, 1);
      end else begin
        chk({tag, "_done"}, done, 1);
        chk({tag, "_result"}, result, exp);
        chk({tag, "_busy_done"}, busy, 1);
      end
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({tag, "_no_redone"}, done, 0);
      chk({tag, "_busy_hold"}, busy, 1);
      chk({tag, "_hold_res"}, result, exp);
    end
    start = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_done_fall"}, done, 0);
    chk({tag, "_result_hold"}, result, exp);
    chk({tag, "_rearmed"}, busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; A = '0; B = '0; opcode = 3'd0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_busy", busy, 0);
      end
    end
    reset = 1'b0;

    run_cmd("add",     8'd200, 8'd100, 3'd1, 16'd300,   1, 0, 0);
    run_cmd("sub",     8'd3,   8'd5,   3'd2, 16'hFFFE,  1, 0, 0);
    run_cmd("not",     8'h0F,  8'h00,  3'd3, 16'h00F0,  1, 0, 0);
    run_cmd("mul_max", 8'd255, 8'd255, 3'd5, 16'hFE01,  3, 0, 0);
    run_cmd("add_max", 8'd255, 8'd255, 3'd1, 16'h01FE,  1, 0, 0);
    run_cmd("inc",     8'd1,   8'd2,   3'd6, 16'd4,     1, 0, 4);
    run_cmd("and",     8'hF0,  8'h3C,  3'd4, 16'h0030,  1, 1, 0);
    run_cmd("rsvd",    8'd5,   8'd6,   3'd7, 16'h0000,  1, 0, 0);
    run_cmd("mul",     8'd12,  8'd13,  3'd5, 16'h009C,  3, 0, 0);

    // Abort a MUL one edge after capture.
    A = 8'd3; B = 8'd4; opcode = 3'd5; start = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_busy", busy, 0);
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("abort_no_done", done, 0);
      chk("abort_idle", busy, 0);
    end
    run_cmd("post_add", 8'd1, 8'd1, 3'd1, 16'd2, 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
